hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the enable and synchronous-reset pins of the PC register, the IF/ID register and the ID/EX register.
- Detects load-use hazards and taken branches/jumps resolved in ID.
- Tracks the multi-cycle mult/div unit with an internal busy FSM so HI/LO readers and new mult/div ops wait.
- Keeps saturating performance counters for stall cycles and flushes.

---
 rtl/mips_pkg.sv | 7 +
 rtl/hazard_ctrl_sat_counter.sv | 13 +
 rtl/hazard_ctrl.sv | 66 ++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the pipeline control blocks and the mult/div unit
package mips_pkg;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;
  localparam int MD_LATENCY_DEF = 8;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: up counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with mult/div busy tracking
module hazard_ctrl import mips_pkg::*; #(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int DELAY_SLOT = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             id_branch_taken,
  input  logic             id_md_use,
  input  logic             ex_md_start,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_rst,
  output logic             id_ex_rst,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic [0:0] state;
  logic [7:0] md_cnt;
  logic       load_use;
  logic       md_hazard;
  logic       stall;
  always_ff @(posedge clk)
    if (rst) begin
      state  <= MD_IDLE;
      md_cnt <= '0;
    end else if (ex_md_start) begin
      state  <= MD_BUSY;
      md_cnt <= 8'(MD_LATENCY - 1);
    end else if (state == MD_BUSY) begin
      if (md_cnt == '0) state <= MD_IDLE;
      else md_cnt <= md_cnt - 1'b1;
    end
  // Reset masks the registered busy flag so an aborted busy period never leaks out
  always_comb begin
    md_busy   = ~rst & (state == MD_BUSY);
    load_use  = ex_mem_read & (ex_rt != REG_ZERO) &
                ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));
    md_hazard = id_md_use & (md_busy | ex_md_start);
    stall     = ~rst & (load_use | md_hazard);
    pc_en     = ~rst & ~stall;
    if_id_en  = ~rst & ~stall;
    if_id_rst = rst | (~stall & id_branch_taken & (DELAY_SLOT == 0));
    id_ex_rst = rst | stall;
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(stall),
    .cnt(stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk),
    .rst(rst),
    .inc(~rst & if_id_rst),
    .cnt(flush_cnt)
  );
endmodule
